// File: rtl/flexbyte_stp_packer_pkg.sv
// Shared types and width helpers for the flexbyte packer.
package flexbyte_pkg;

    typedef logic [7:0] byte_t;

    localparam bit MSB_FIRST = 1'b1;
    localparam bit LSB_FIRST = 1'b0;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int acc_bytes(input int in_b, input int out_b);
        return out_b + in_b - 1;
    endfunction

endpackage

// File: rtl/flexbyte_stp_packer_if.sv
// Byte-group input stream and packed-word output stream.
interface flexbyte_stp_packer_if
    import flexbyte_pkg::*;
#(
    parameter int IN_BYTES  = 2,
    parameter int OUT_BYTES = 4
) ();

    logic                           in_valid;
    logic                           in_ready;
    logic [IN_BYTES*8-1:0]          in_data;
    logic [cnt_w(IN_BYTES)-1:0]     in_nbytes;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [OUT_BYTES*8-1:0]         out_data;
    logic [cnt_w(OUT_BYTES)-1:0]    out_nbytes;
    logic                           out_last;

    modport slave (
        input  in_valid, in_data, in_nbytes, in_last, out_ready,
        output in_ready, out_valid, out_data, out_nbytes, out_last
    );

    modport master (
        output in_valid, in_data, in_nbytes, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_nbytes, out_last
    );

endinterface

// File: rtl/flexbyte_stp_packer_align.sv
// Lane reorder: beat -> earliest-first bytes (PACK=0),
// earliest-first bytes + count -> justified word (PACK=1).
module flexbyte_align
    import flexbyte_pkg::*;
#(
    parameter bit MSB   = MSB_FIRST,
    parameter int BYTES = 4,
    parameter bit PACK  = 1'b0
) (
    input  byte_t [BYTES-1:0]       src,
    input  logic [cnt_w(BYTES)-1:0] cnt,
    output byte_t [BYTES-1:0]       dst
);

    always_comb begin
        int n;
        n = int'(cnt);
        dst = '0;
        for (int i = 0; i < BYTES; i++) begin
            for (int j = 0; j < BYTES; j++) begin
                if (MSB) begin
                    if (i < n && j == n - 1 - i) dst[i] = src[j];
                end else if (PACK) begin
                    if (i >= BYTES - n && j == i - (BYTES - n)) dst[i] = src[j];
                end else begin
                    if (i < n && j == i) dst[i] = src[j];
                end
            end
        end
    end

endmodule

// File: rtl/flexbyte_stp_packer.sv
// Packs variable-length byte groups into OUT_BYTES words with
// residual carry-over and in_last flush of partial words.
module flexbyte_stp_packer
    import flexbyte_pkg::*;
#(
    parameter bit MSB       = MSB_FIRST,
    parameter int IN_BYTES  = 2,
    parameter int OUT_BYTES = 4
) (
    input logic                  clk,
    input logic                  n_rst,
    flexbyte_stp_packer_if.slave bus
);

    localparam int ACC = acc_bytes(IN_BYTES, OUT_BYTES);
    localparam int CW  = cnt_w(ACC);
    localparam int IW  = cnt_w(IN_BYTES);
    localparam int OW  = cnt_w(OUT_BYTES);

    generate
        if (OUT_BYTES < IN_BYTES || IN_BYTES < 1) begin : g_bad_cfg
            $error("flexbyte_stp_packer: need 1 <= IN_BYTES <= OUT_BYTES");
        end
    endgenerate

    byte_t [ACC-1:0]       acc_q;
    byte_t [ACC-1:0]       acc_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         take;
    logic [CW-1:0]         surv;
    logic [CW-1:0]         n_in;
    logic                  flush_q;
    logic                  ready;
    logic                  accept;
    logic                  full;
    logic                  load;
    logic                  empties;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [OUT_BYTES*8-1:0] out_data_q;
    logic [OW-1:0]         out_nbytes_q;
    byte_t [IN_BYTES-1:0]  in_ef;
    byte_t [OUT_BYTES-1:0] word;

    flexbyte_align #(
        .MSB   (MSB),
        .BYTES (IN_BYTES),
        .PACK  (1'b0)
    ) u_in_align (
        .src (bus.in_data),
        .cnt (bus.in_nbytes),
        .dst (in_ef)
    );

    flexbyte_align #(
        .MSB   (MSB),
        .BYTES (OUT_BYTES),
        .PACK  (1'b1)
    ) u_out_align (
        .src (acc_q[OUT_BYTES-1:0]),
        .cnt (OW'(take)),
        .dst (word)
    );

    always_comb begin
        ready   = (cnt_q < CW'(OUT_BYTES)) && !flush_q;
        accept  = bus.in_valid && ready && (bus.in_nbytes != '0)
                  && (bus.in_nbytes <= IW'(IN_BYTES));
        full    = cnt_q >= CW'(OUT_BYTES);
        load    = (!out_valid_q || bus.out_ready)
                  && (full || (flush_q && cnt_q != '0));
        take    = '0;
        if (load) take = full ? CW'(OUT_BYTES) : cnt_q;
        empties = load && (take == cnt_q);
        surv    = cnt_q - take;
        n_in    = accept ? CW'(bus.in_nbytes) : '0;
        cnt_d   = surv + n_in;
        // Residue slides down by 'take'; new bytes land right behind it.
        acc_d = '0;
        for (int i = 0; i < ACC; i++) begin
            for (int j = 0; j < ACC; j++) begin
                if (j == i + int'(take) && j < int'(cnt_q)) acc_d[i] = acc_q[j];
            end
            for (int k = 0; k < IN_BYTES; k++) begin
                if (k < int'(n_in) && i == int'(surv) + k) acc_d[i] = in_ef[k];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_nbytes_q <= '0;
            out_last_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (accept && bus.in_last) flush_q <= 1'b1;
            else if (empties)          flush_q <= 1'b0;
            if (load) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= word;
                out_nbytes_q <= OW'(take);
                out_last_q   <= flush_q && empties;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_nbytes = out_nbytes_q;
    assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_flexbyte_stp_packer.sv
// Bench for flexbyte_stp_packer: vector table, corner sequences and
// randomized streams against a byte-queue reference model.
module tb_flexbyte_stp_packer;
    import flexbyte_pkg::*;

    typedef struct {
        logic [31:0] d;
        int          n;
        bit          last;
    } word_t;

    typedef struct {
        int               nb;
        logic [3:0][15:0] d;
        logic [3:0][1:0]  n;
        logic [3:0]       l;
        int               nw;
        logic [1:0][31:0] wd;
        logic [1:0][2:0]  wn;
        logic [1:0]       wl;
    } vec_t;

    logic  clk   = 1'b0;
    logic  n_rst = 1'b0;
    bit    rnd_a = 1'b0;
    bit    rnd_b = 1'b0;
    int    checks = 0;
    int    errors = 0;
    word_t got_a[$];
    word_t got_b[$];
    word_t got_c[$];
    byte_t mq[$];
    word_t mexp[$];
    vec_t  tab[6];

    always #5 clk = ~clk;

    flexbyte_stp_packer_if #(.IN_BYTES(2), .OUT_BYTES(4)) ifa ();
    flexbyte_stp_packer_if #(.IN_BYTES(2), .OUT_BYTES(4)) ifb ();
    flexbyte_stp_packer_if #(.IN_BYTES(1), .OUT_BYTES(4)) ifc ();

    flexbyte_stp_packer #(.MSB(1'b1), .IN_BYTES(2), .OUT_BYTES(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .bus(ifa)
    );
    flexbyte_stp_packer #(.MSB(1'b0), .IN_BYTES(2), .OUT_BYTES(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .bus(ifb)
    );
    flexbyte_stp_packer #(.MSB(1'b1), .IN_BYTES(1), .OUT_BYTES(4)) dut_c (
        .clk(clk), .n_rst(n_rst), .bus(ifc)
    );

    always @(negedge clk) begin
        if (n_rst && ifa.out_valid && ifa.out_ready)
            got_a.push_back('{ifa.out_data, int'(ifa.out_nbytes), ifa.out_last});
        if (n_rst && ifb.out_valid && ifb.out_ready)
            got_b.push_back('{ifb.out_data, int'(ifb.out_nbytes), ifb.out_last});
        if (n_rst && ifc.out_valid && ifc.out_ready)
            got_c.push_back('{ifc.out_data, int'(ifc.out_nbytes), ifc.out_last});
    end

    always @(posedge clk) begin
        #1;
        if (rnd_a) ifa.out_ready = 1'($urandom_range(0, 1));
        if (rnd_b) ifb.out_ready = 1'($urandom_range(0, 1));
    end

    function automatic word_t mkw(input logic [31:0] d, input int n, input bit l);
        word_t w;
        w.d = d;
        w.n = n;
        w.last = l;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input word_t a, input word_t e);
        chk({name, "_data"}, a.d, e.d);
        chk({name, "_nbytes"}, 32'(a.n), 32'(e.n));
        chk({name, "_last"}, 32'(a.last), 32'(e.last));
    endtask

    task automatic set_in(input int sel, input bit v, input logic [15:0] d,
                          input int n, input bit l);
        case (sel)
            0: begin
                ifa.in_valid = v; ifa.in_data = d;
                ifa.in_nbytes = 2'(n); ifa.in_last = l;
            end
            1: begin
                ifb.in_valid = v; ifb.in_data = d;
                ifb.in_nbytes = 2'(n); ifb.in_last = l;
            end
            default: begin
                ifc.in_valid = v; ifc.in_data = d[7:0];
                ifc.in_nbytes = 1'(n); ifc.in_last = l;
            end
        endcase
    endtask

    function automatic bit rdy(input int sel);
        case (sel)
            0:       return ifa.in_ready;
            1:       return ifb.in_ready;
            default: return ifc.in_ready;
        endcase
    endfunction

    function automatic int gsize(input int sel);
        case (sel)
            0:       return got_a.size();
            1:       return got_b.size();
            default: return got_c.size();
        endcase
    endfunction

    function automatic word_t gget(input int sel, input int k);
        case (sel)
            0:       return got_a[k];
            1:       return got_b[k];
            default: return got_c[k];
        endcase
    endfunction

    task automatic set_ready(input int sel, input bit v);
        @(posedge clk);
        #1;
        case (sel)
            0:       ifa.out_ready = v;
            1:       ifb.out_ready = v;
            default: ifc.out_ready = v;
        endcase
    endtask

    task automatic send(input int sel, input logic [15:0] d, input int n, input bit l);
        int t = 0;
        @(negedge clk);
        set_in(sel, 1'b1, d, n, l);
        while (!rdy(sel) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: in_ready 0, required 1", sel);
        end
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic wait_words(input int sel, input int cnt, input int budget,
                              input string name);
        int t = 0;
        while (gsize(sel) < cnt && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_count"}, 32'(gsize(sel)), 32'(cnt));
    endtask

    // Reference: a plain byte FIFO; words are cut every 4 bytes and at packet end,
    // then formatted the way the legacy shifter would after n shifts from zero.
    function automatic void emit(input bit msb, input int k, input bit l);
        word_t w;
        byte_t b;
        w = mkw(32'h0, k, l);
        for (int i = 0; i < k; i++) begin
            b = mq.pop_front();
            if (msb) w.d = {w.d[23:0], b};
            else     w.d = {b, w.d[31:8]};
        end
        mexp.push_back(w);
    endfunction

    function automatic void model_beat(input bit msb, input logic [15:0] d,
                                       input int n, input bit l);
        if (n < 1 || n > 2) return;
        for (int i = 0; i < n; i++)
            mq.push_back(msb ? d[8*(n-1-i) +: 8] : d[8*i +: 8]);
        if (!l) begin
            while (mq.size() >= 4) emit(msb, 4, 1'b0);
        end else begin
            while (mq.size() > 4) emit(msb, 4, 1'b0);
            emit(msb, mq.size(), 1'b1);
        end
    endfunction

    task automatic run_random(input int sel, input bit msb, input int beats);
        logic [15:0] d;
        int          n;
        bit          l;
        mq.delete();
        mexp.delete();
        for (int b = 0; b < beats; b++) begin
            d = 16'($urandom);
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2));
            l = ($urandom_range(0, 5) == 0);
            model_beat(msb, d, n, l);
            send(sel, d, n, l);
        end
        wait_words(sel, mexp.size(), 4000, $sformatf("rand%0d", sel));
        for (int k = 0; k < mexp.size() && k < gsize(sel); k++)
            chk_word($sformatf("rand%0d_w%0d", sel, k), gget(sel, k), mexp[k]);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 16'h0, 0, 1'b0);
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        ifc.out_ready = 1'b1;

        tab[0] = '{2, {16'h0, 16'h0, 16'h1234, 16'h0F08}, {2'd0, 2'd0, 2'd2, 2'd2},
                   4'b0000, 1, {32'h0, 32'h0F081234}, {3'd0, 3'd4}, 2'b00};
        tab[1] = '{4, {16'h0011, 16'hDDEE, 16'hBBCC, 16'h00AA}, {2'd1, 2'd2, 2'd2, 2'd1},
                   4'b1000, 2, {32'h0000EE11, 32'hAABBCCDD}, {3'd2, 3'd4}, 2'b10};
        tab[2] = '{1, {16'h0, 16'h0, 16'h0, 16'h1234}, {2'd0, 2'd0, 2'd0, 2'd2},
                   4'b0001, 1, {32'h0, 32'h00001234}, {3'd0, 3'd2}, 2'b01};
        tab[3] = '{4, {16'h0001, 16'h00EF, 16'h00CD, 16'h00AB}, {2'd1, 2'd1, 2'd1, 2'd1},
                   4'b1000, 1, {32'h0, 32'hABCDEF01}, {3'd0, 3'd4}, 2'b01};
        tab[4] = '{3, {16'h0, 16'h0005, 16'h0304, 16'h0102}, {2'd0, 2'd1, 2'd2, 2'd2},
                   4'b0100, 2, {32'h00000005, 32'h01020304}, {3'd1, 3'd4}, 2'b10};
        tab[5] = '{3, {16'h0, 16'hFF66, 16'hEE99, 16'h7F55}, {2'd0, 2'd1, 2'd0, 2'd1},
                   4'b0110, 1, {32'h0, 32'h00005566}, {3'd0, 3'd2}, 2'b01};

        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(ifa.out_valid), 32'h0);
        chk("rst_out_data", ifa.out_data, 32'h0);
        chk("rst_out_nbytes", 32'(ifa.out_nbytes), 32'h0);
        chk("rst_out_last", 32'(ifa.out_last), 32'h0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(ifa.in_ready), 32'h1);

        for (int t = 0; t < 6; t++) begin
            got_a.delete();
            for (int b = 0; b < tab[t].nb; b++)
                send(0, tab[t].d[b], int'(tab[t].n[b]), tab[t].l[b]);
            wait_words(0, tab[t].nw, 50, $sformatf("vec%0d", t));
            for (int k = 0; k < tab[t].nw && k < got_a.size(); k++)
                chk_word($sformatf("vec%0d_w%0d", t, k), got_a[k],
                         mkw(tab[t].wd[k], int'(tab[t].wn[k]), tab[t].wl[k]));
        end

        // Backpressure: one word parked at the output, a second filling the accumulator.
        set_ready(0, 1'b0);
        got_a.delete();
        send(0, 16'h0102, 2, 1'b0);
        send(0, 16'h0304, 2, 1'b0);
        send(0, 16'h0506, 2, 1'b0);
        send(0, 16'h0708, 2, 1'b0);
        repeat (3) @(negedge clk);
        chk("bp_out_valid", 32'(ifa.out_valid), 32'h1);
        chk("bp_out_data", ifa.out_data, 32'h01020304);
        chk("bp_in_ready", 32'(ifa.in_ready), 32'h0);
        chk("bp_none_taken", 32'(got_a.size()), 32'h0);
        @(negedge clk);
        chk("bp_data_stable", ifa.out_data, 32'h01020304);
        set_ready(0, 1'b1);
        wait_words(0, 2, 20, "bp");
        if (got_a.size() >= 2) begin
            chk_word("bp_w0", got_a[0], mkw(32'h01020304, 4, 1'b0));
            chk_word("bp_w1", got_a[1], mkw(32'h05060708, 4, 1'b0));
        end

        // Reset with a word held and two residue bytes in the accumulator.
        set_ready(0, 1'b0);
        send(0, 16'h0102, 2, 1'b0);
        send(0, 16'h0304, 2, 1'b0);
        send(0, 16'h0506, 2, 1'b0);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(ifa.out_valid), 32'h0);
        chk("mid_rst_out_data", ifa.out_data, 32'h0);
        chk("mid_rst_out_nbytes", 32'(ifa.out_nbytes), 32'h0);
        chk("mid_rst_out_last", 32'(ifa.out_last), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        got_a.delete();
        #1;
        chk("mid_rst_in_ready", 32'(ifa.in_ready), 32'h1);
        set_ready(0, 1'b1);
        send(0, 16'h0A0B, 2, 1'b1);
        wait_words(0, 1, 20, "post_rst");
        if (got_a.size() >= 1)
            chk_word("post_rst_w0", got_a[0], mkw(32'h00000A0B, 2, 1'b1));

        send(1, 16'h0F08, 2, 1'b0);
        send(1, 16'h0F08, 2, 1'b0);
        send(1, 16'h00AB, 1, 1'b1);
        wait_words(1, 2, 20, "lsb");
        if (got_b.size() >= 2) begin
            chk_word("lsb_w0", got_b[0], mkw(32'h0F080F08, 4, 1'b0));
            chk_word("lsb_w1", got_b[1], mkw(32'hAB000000, 1, 1'b1));
        end

        for (int i = 0; i < 4; i++) send(2, 16'h00FF, 1, 1'b0);
        for (int i = 0; i < 4; i++) send(2, 16'h0000, 1, 1'b0);
        wait_words(2, 2, 40, "in1");
        if (got_c.size() >= 2) begin
            chk_word("in1_w0", got_c[0], mkw(32'hFFFFFFFF, 4, 1'b0));
            chk_word("in1_w1", got_c[1], mkw(32'h00000000, 4, 1'b0));
        end

        @(posedge clk);
        #1;
        rnd_a = 1'b1;
        got_a.delete();
        run_random(0, 1'b1, 300);
        rnd_a = 1'b0;
        set_ready(0, 1'b1);

        @(posedge clk);
        #1;
        rnd_b = 1'b1;
        got_b.delete();
        run_random(1, 1'b0, 300);
        rnd_b = 1'b0;
        set_ready(1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
